// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Data-memory initiator that turns byte/half/word load and store
//               requests into word-addressed accesses, with read-modify-write
//               for sub-word stores and sign/zero extension of load data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DAT_WIDTH  = 32,
    parameter int MEM_WORDS  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DAT_WIDTH-1:0]  req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [DAT_WIDTH-1:0]  rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DAT_WIDTH-1:0]  mem_wdata,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DAT_WIDTH-1:0]  mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WRITE  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    state_t                r_state;
    logic                  r_we;
    logic                  r_unsigned;
    logic                  r_err;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DAT_WIDTH-1:0]  r_wdata;
    logic [DAT_WIDTH-1:0]  r_rbuf;

    logic [ADDR_WIDTH-1:0] w_req_idx;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_req_err;
    logic [DAT_WIDTH-1:0]  w_merged;
    logic [DAT_WIDTH-1:0]  w_ext;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic                  w_in_mem;

    assign w_req_idx = {2'b00, req_addr[ADDR_WIDTH-1:2]};
    assign w_idx     = {2'b00, r_addr[ADDR_WIDTH-1:2]};

    always_comb begin
        w_req_err = 1'b0;
        case (req_size)
            c_SIZE_BYTE: w_req_err = 1'b0;
            c_SIZE_HALF: w_req_err = req_addr[0];
            c_SIZE_WORD: w_req_err = |req_addr[1:0];
            default:     w_req_err = 1'b1;
        endcase
        if (w_req_idx >= ADDR_WIDTH'(MEM_WORDS)) begin
            w_req_err = 1'b1;
        end
    end

    // Little-endian lane replacement on the word captured during ACCESS
    always_comb begin
        w_merged = r_rbuf;
        case (r_size)
            c_SIZE_BYTE: w_merged[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
            c_SIZE_HALF: w_merged[{r_addr[1], 4'b0000} +: 16]  = r_wdata[15:0];
            default:     w_merged = r_wdata;
        endcase
    end

    assign w_byte = r_rbuf[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_rbuf[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_ext = r_rbuf;
        case (r_size)
            c_SIZE_BYTE: w_ext = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            c_SIZE_HALF: w_ext = {{16{~r_unsigned & w_half[15]}}, w_half};
            default:     w_ext = r_rbuf;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rbuf     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_unsigned <= req_unsigned;
                        r_size     <= req_size;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_err      <= w_req_err;
                        r_state    <= w_req_err ? S_RESP : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_rbuf  <= mem_rdata;
                    r_state <= r_we ? S_WRITE : S_RESP;
                end
                S_WRITE: begin
                    r_state <= S_RESP;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode only from registered state so a WRITE cycle that meets
    // a reset edge still presents its strobe and completes the write.
    assign w_in_mem  = (r_state == S_ACCESS) || (r_state == S_WRITE);
    assign req_ready = (r_state == S_IDLE);
    assign mem_read  = (r_state == S_ACCESS);
    assign mem_write = (r_state == S_WRITE);
    assign mem_addr  = w_in_mem ? w_idx : '0;
    assign mem_wdata = (r_state == S_WRITE) ? w_merged : '0;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_err   = (r_state == S_RESP) && r_err;
    assign rsp_rdata = ((r_state == S_RESP) && !r_err && !r_we) ? w_ext : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit with a
//               64-word behavioural data memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    logic [31:0] mem [64];
    logic        mem_init;
    int          checks;
    int          errors;
    int          n_reads;
    int          n_writes;

    mem_access_unit #(
        .ADDR_WIDTH(32),
        .DAT_WIDTH (32),
        .MEM_WORDS (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_rdata   (rsp_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= i;
        end else if (mem_write && mem_addr < 64) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
    end

    assign mem_rdata = (mem_addr < 64) ? mem[mem_addr[5:0]] : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (mem_read)  n_reads++;
        if (mem_write) n_writes++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Present a request while IDLE and return #1 after the accepting edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        check("accept_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] exp);
        issue(1'b0, sz, uns, a, 32'h0);
        check({tag, "_rd"}, {31'd0, mem_read}, 32'd1);
        check({tag, "_addr"}, mem_addr, a >> 2);
        check({tag, "_early"}, {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_vld"}, {30'd0, rsp_valid, rsp_err}, 32'd2);
        check({tag, "_data"}, rsp_rdata, exp);
        @(posedge clk); #1;
    endtask

    task automatic do_store(input string tag, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_word);
        issue(1'b1, sz, 1'b0, a, wd);
        check({tag, "_rd"}, {31'd0, mem_read}, 32'd1);
        @(posedge clk); #1;
        check({tag, "_wr"}, {30'd0, mem_write, rsp_valid}, 32'd2);
        check({tag, "_waddr"}, mem_addr, a >> 2);
        check({tag, "_wdata"}, mem_wdata, exp_word);
        @(posedge clk); #1;
        check({tag, "_vld"}, {30'd0, rsp_valid, rsp_err}, 32'd2);
        check({tag, "_rdata"}, rsp_rdata, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_err(input string tag, input logic [1:0] sz, input logic [31:0] a);
        int r0;
        int w0;
        r0 = n_reads;
        w0 = n_writes;
        issue(1'b0, sz, 1'b0, a, 32'h0);
        check({tag, "_vld"}, {30'd0, rsp_valid, rsp_err}, 32'd3);
        check({tag, "_rdata"}, rsp_rdata, 32'd0);
        @(posedge clk); #1;
        check({tag, "_strobes"}, n_reads + n_writes, r0 + w0);
        check({tag, "_idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int w0;
        checks       = 0;
        errors       = 0;
        n_reads      = 0;
        n_writes     = 0;
        rst          = 1'b1;
        mem_init     = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_strobes", {28'd0, rsp_valid, rsp_err, mem_read, mem_write}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        rst      = 1'b0;
        n_reads  = 0;
        n_writes = 0;

        do_load("lw14", 2'b10, 1'b0, 32'h14, 32'h00000005);

        do_store("sw20", 2'b10, 32'h20, 32'h80FF7F01, 32'h80FF7F01);
        do_load("lb20",  2'b00, 1'b0, 32'h20, 32'h00000001);
        do_load("lb23",  2'b00, 1'b0, 32'h23, 32'hFFFFFF80);
        do_load("lbu23", 2'b00, 1'b1, 32'h23, 32'h00000080);
        do_load("lh22",  2'b01, 1'b0, 32'h22, 32'hFFFF80FF);
        do_load("lhu20", 2'b01, 1'b1, 32'h20, 32'h00007F01);

        do_store("sb29", 2'b00, 32'h29, 32'h000000AA, 32'h0000AA0A);
        do_store("sh2a", 2'b01, 32'h2A, 32'h0000BEEF, 32'hBEEFAA0A);
        do_load("lw28",  2'b10, 1'b0, 32'h28, 32'hBEEFAA0A);

        do_err("e_lw02",  2'b10, 32'h02);
        do_err("e_lh03",  2'b01, 32'h03);
        do_err("e_sz11",  2'b11, 32'h00);
        do_err("e_lw100", 2'b10, 32'h100);

        // Two loads with req_valid held; fields disturbed while not ready
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h04; req_wdata = 32'h0;
        check("b2b_rdy0", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        check("b2b_rdy1", {31'd0, req_ready}, 32'd0);
        check("b2b_addrA", mem_addr, 32'd1);
        req_we = 1'b1; req_size = 2'b00; req_addr = 32'h3C; req_wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        check("b2b_rdy2", {31'd0, req_ready}, 32'd0);
        check("b2b_rspA", rsp_rdata, 32'd1);
        check("b2b_nowr", {31'd0, mem_write}, 32'd0);
        req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0C; req_wdata = 32'h0;
        @(posedge clk); #1;
        check("b2b_rdy3", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b_accB", {31'd0, mem_read}, 32'd1);
        check("b2b_addrB", mem_addr, 32'd3);
        @(posedge clk); #1;
        check("b2b_rspB", rsp_rdata, 32'd3);
        @(posedge clk); #1;

        // Reset during ACCESS of a byte store
        w0 = n_writes;
        issue(1'b1, 2'b00, 1'b0, 32'h30, 32'h00000055);
        check("rstm_acc", {31'd0, mem_read}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstm_idle", {31'd0, req_ready}, 32'd1);
        check("rstm_rsp", {31'd0, rsp_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rstm_nowr", n_writes, w0);
        do_load("lw30", 2'b10, 1'b0, 32'h30, 32'h0000000C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
